// File: rtl/beep_tone_decoder.sv
`default_nettype none
// ============================================================================
// Module : beep_tone_decoder
// Brief  : Measures buzzer PWM tone periods and decodes them into note codes.
// Rev    : 1.0 - initial release
// ============================================================================
module beep_tone_decoder #(
    parameter int CLK_PRE     = 50_000_000,
    parameter int SIL_TIMEOUT = 500_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pwm_in,
    output logic        note_valid,
    output logic [3:0]  note_code,
    output logic [17:0] note_period,
    output logic        silence,
    output logic [7:0]  event_cnt
);

    localparam logic [1:0]  c_IDLE  = 2'd0;
    localparam logic [1:0]  c_ACQ   = 2'd1;
    localparam logic [1:0]  c_TRACK = 2'd2;
    localparam logic [17:0] c_SAT   = 18'h3FFFF;
    // The counter saturates, so a timeout beyond its range fires at saturation.
    localparam logic [17:0] c_SIL   = (SIL_TIMEOUT > 262143) ? c_SAT : 18'(SIL_TIMEOUT);

    function automatic int freq_of(input int k);
        int f;
        case (k)
            1:       f = 262;
            2:       f = 294;
            3:       f = 330;
            4:       f = 349;
            5:       f = 392;
            6:       f = 440;
            7:       f = 494;
            8:       f = 523;
            9:       f = 587;
            10:      f = 659;
            11:      f = 698;
            12:      f = 784;
            13:      f = 880;
            default: f = 988;
        endcase
        return f;
    endfunction

    function automatic logic [17:0] abs_diff(input logic [17:0] a, input logic [17:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    logic        r_meta;
    logic        r_sync;
    logic        r_sync_q;
    logic [17:0] r_cnt;
    logic [1:0]  r_state;
    logic [17:0] r_ref;
    logic [17:0] r_period;
    logic [3:0]  r_code;
    logic        r_valid;
    logic [7:0]  r_events;

    logic        w_fall;
    logic        w_timeout;
    logic        w_ref_match;
    logic        w_per_match;
    logic [14:1] w_match;
    logic [3:0]  w_class;
    logic [1:0]  w_state_nxt;
    logic [17:0] w_ref_nxt;
    logic [17:0] w_period_nxt;
    logic [3:0]  w_code_nxt;

    assign w_fall      = r_sync_q & ~r_sync;
    assign w_timeout   = (r_cnt == c_SIL);
    assign w_ref_match = (abs_diff(r_cnt, r_ref) <= (r_ref >> 6));
    assign w_per_match = (abs_diff(r_cnt, r_period) <= (r_period >> 6));

    for (genvar k = 1; k <= 14; k++) begin : g_class
        localparam logic [17:0] c_NOM = 18'(CLK_PRE / freq_of(k));
        assign w_match[k] = (abs_diff(r_cnt, c_NOM) <= (c_NOM >> 6));
    end

    // Walk downwards so the lowest matching note index wins.
    always_comb begin
        w_class = 4'd0;
        for (int k = 14; k >= 1; k--) begin
            if (w_match[k]) w_class = 4'(k);
        end
        if (r_cnt == c_SAT) w_class = 4'd0;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_ref_nxt    = r_ref;
        w_period_nxt = r_period;
        w_code_nxt   = r_code;
        case (r_state)
            c_IDLE: begin
                if (w_fall) begin
                    w_state_nxt = c_ACQ;
                    w_ref_nxt   = r_cnt;
                end
            end
            c_ACQ: begin
                if (w_fall) begin
                    if (w_ref_match) begin
                        w_state_nxt  = c_TRACK;
                        w_period_nxt = r_cnt;
                        w_code_nxt   = w_class;
                    end else begin
                        w_ref_nxt = r_cnt;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = c_IDLE;
                    w_code_nxt  = 4'd0;
                end
            end
            c_TRACK: begin
                if (w_fall) begin
                    if (w_per_match) begin
                        w_period_nxt = r_cnt;
                    end else begin
                        w_state_nxt = c_ACQ;
                        w_ref_nxt   = r_cnt;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = c_IDLE;
                    w_code_nxt  = 4'd0;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta   <= 1'b1;
            r_sync   <= 1'b1;
            r_sync_q <= 1'b1;
            r_cnt    <= 18'd0;
            r_state  <= c_IDLE;
            r_ref    <= 18'd0;
            r_period <= 18'd0;
            r_code   <= 4'd0;
            r_valid  <= 1'b0;
            r_events <= 8'd0;
        end else begin
            r_meta   <= pwm_in;
            r_sync   <= r_meta;
            r_sync_q <= r_sync;
            if (w_fall) begin
                r_cnt <= 18'd1;
            end else if (r_cnt != c_SAT) begin
                r_cnt <= r_cnt + 18'd1;
            end
            r_state  <= w_state_nxt;
            r_ref    <= w_ref_nxt;
            r_period <= w_period_nxt;
            r_code   <= w_code_nxt;
            r_valid  <= (w_code_nxt != r_code);
            if (w_code_nxt != r_code) r_events <= r_events + 8'd1;
        end
    end

    assign note_valid  = r_valid;
    assign note_code   = r_code;
    assign note_period = r_period;
    assign silence     = (r_state == c_IDLE);
    assign event_cnt   = r_events;

endmodule
`default_nettype wire

// File: tb/tb_beep_tone_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : tb_beep_tone_decoder
// Brief  : Self-checking bench for beep_tone_decoder with a period-level model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_beep_tone_decoder;

    // Scaled clock so every note period stays a few dozen to a few hundred cycles.
    localparam int CLK_PRE = 60_000;
    localparam int SIL     = 600;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        pwm_in = 1'b1;
    logic        note_valid;
    logic [3:0]  note_code;
    logic [17:0] note_period;
    logic        silence;
    logic [7:0]  event_cnt;

    beep_tone_decoder #(
        .CLK_PRE     (CLK_PRE),
        .SIL_TIMEOUT (SIL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pwm_in      (pwm_in),
        .note_valid  (note_valid),
        .note_code   (note_code),
        .note_period (note_period),
        .silence     (silence),
        .event_cnt   (event_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         pulses = 0;
    int         zero_pulses = 0;
    int         last_pulse_cyc = -1;
    logic [3:0] last_pulse_code = 4'd0;
    always @(posedge clk) begin
        #2;
        if (note_valid === 1'b1) begin
            pulses++;
            last_pulse_cyc  = cyc;
            last_pulse_code = note_code;
            if (note_code == 4'd0) zero_pulses++;
        end
    end

    // Reference model: works on whole periods between driven falling edges.
    int freq_tab [14] = '{262, 294, 330, 349, 392, 440, 494, 523, 587, 659, 698, 784, 880, 988};
    int m_state;       // 0 idle, 1 acquiring, 2 tracking
    int m_ref;
    int m_per;
    int m_code;
    int m_events;
    int pulse_base;
    int last_fall_cyc;

    function automatic int nominal(input int k);
        return CLK_PRE / freq_tab[k-1];
    endfunction

    function automatic int absd(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    function automatic int classify(input int p);
        if (p >= 262143) return 0;
        for (int k = 1; k <= 14; k++) begin
            if (absd(p, nominal(k)) <= nominal(k) / 64) return k;
        end
        return 0;
    endfunction

    task automatic set_code(input int c);
        if (c != m_code) m_events++;
        m_code = c;
    endtask

    task automatic model_reset();
        m_state = 0; m_ref = 0; m_per = 0; m_code = 0; m_events = 0;
        pulse_base = pulses;
        last_fall_cyc = cyc;
    endtask

    task automatic model_timeout();
        if (m_state != 0) begin
            m_state = 0;
            set_code(0);
        end
    endtask

    task automatic model_fall(input int p);
        case (m_state)
            0: begin m_state = 1; m_ref = p; end
            1: begin
                if (absd(p, m_ref) <= m_ref / 64) begin
                    m_state = 2; m_per = p; set_code(classify(p));
                end else m_ref = p;
            end
            default: begin
                if (absd(p, m_per) <= m_per / 64) m_per = p;
                else begin m_state = 1; m_ref = p; end
            end
        endcase
    endtask

    // Drives one falling edge now, then holds a tone period of p cycles.
    task automatic fall(input int p);
        int gap;
        gap = cyc - last_fall_cyc;
        if (gap > SIL) model_timeout();
        model_fall(gap);
        last_fall_cyc = cyc;
        pwm_in = 1'b0;
        repeat (p / 2) @(negedge clk);
        pwm_in = 1'b1;
        repeat (p - p / 2) @(negedge clk);
    endtask

    task automatic go_idle();
        repeat (SIL + 20) @(negedge clk);
        if (cyc - last_fall_cyc > SIL) model_timeout();
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        checks++; if (note_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0d expected 0", note_valid); end
        checks++; if (note_code !== 4'd0) begin errors++; $display("FAIL rst_code got %0d expected 0", note_code); end
        checks++; if (note_period !== 18'd0) begin errors++; $display("FAIL rst_period got %0d expected 0", note_period); end
        checks++; if (silence !== 1'b1) begin errors++; $display("FAIL rst_silence got %0d expected 1", silence); end
        checks++; if (event_cnt !== 8'd0) begin errors++; $display("FAIL rst_events got %0d expected 0", event_cnt); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (700) @(negedge clk);
    endtask

    task automatic test_la();
        int f3;
        int p0;
        p0 = pulses;
        f3 = 0;
        for (int i = 1; i <= 5; i++) begin
            if (i == 3) f3 = cyc;
            fall(68);
        end
        checks++; if (note_code !== 4'd13) begin errors++; $display("FAIL la_code got %0d expected 13", note_code); end
        checks++; if (pulses - p0 != 1) begin errors++; $display("FAIL la_pulses got %0d expected 1", pulses - p0); end
        checks++; if (last_pulse_cyc - f3 != 3) begin errors++; $display("FAIL la_latency got %0d expected 3", last_pulse_cyc - f3); end
        checks++; if (note_period !== 18'd68) begin errors++; $display("FAIL la_period got %0d expected 68", note_period); end
        checks++; if (silence !== 1'b0) begin errors++; $display("FAIL la_silence got %0d expected 0", silence); end
        checks++; if (event_cnt !== 8'd1) begin errors++; $display("FAIL la_events got %0d expected 1", event_cnt); end
    endtask

    task automatic test_do_low();
        repeat (3) fall(229);
        checks++; if (note_code !== 4'd1) begin errors++; $display("FAIL do_code got %0d expected 1", note_code); end
        checks++; if (note_period !== 18'd229) begin errors++; $display("FAIL do_period got %0d expected 229", note_period); end
    endtask

    task automatic test_la_si();
        logic [7:0] e0;
        int z0;
        go_idle();
        e0 = event_cnt;
        z0 = zero_pulses;
        repeat (4) fall(68);
        checks++; if (note_code !== 4'd13) begin errors++; $display("FAIL lasi_code_la got %0d expected 13", note_code); end
        fall(60);
        fall(60);
        checks++; if (note_code !== 4'd13) begin errors++; $display("FAIL lasi_code_hold got %0d expected 13", note_code); end
        fall(60);
        checks++; if (note_code !== 4'd14) begin errors++; $display("FAIL lasi_code_si got %0d expected 14", note_code); end
        fall(60);
        checks++; if (event_cnt !== 8'(e0 + 8'd2)) begin errors++; $display("FAIL lasi_events got %0d expected %0d", event_cnt, 8'(e0 + 8'd2)); end
        checks++; if (zero_pulses != z0) begin errors++; $display("FAIL lasi_zero_pulse got %0d expected %0d", zero_pulses, z0); end
    endtask

    task automatic test_silence();
        int lf;
        int p0;
        repeat (3) fall(76);
        checks++; if (note_code !== 4'd12) begin errors++; $display("FAIL sil_code_so got %0d expected 12", note_code); end
        lf = last_fall_cyc;
        p0 = pulses;
        go_idle();
        checks++; if (note_code !== 4'd0) begin errors++; $display("FAIL sil_code got %0d expected 0", note_code); end
        checks++; if (silence !== 1'b1) begin errors++; $display("FAIL sil_silence got %0d expected 1", silence); end
        checks++; if (pulses - p0 != 1) begin errors++; $display("FAIL sil_pulses got %0d expected 1", pulses - p0); end
        checks++; if (last_pulse_cyc - lf != SIL + 3) begin errors++; $display("FAIL sil_timing got %0d expected %0d", last_pulse_cyc - lf, SIL + 3); end
        checks++; if (note_period !== 18'd76) begin errors++; $display("FAIL sil_period got %0d expected 76", note_period); end
    endtask

    task automatic test_timeout_edge();
        int t;
        repeat (3) fall(68);
        fall(SIL);
        fall(68);
        checks++; if (silence !== 1'b0) begin errors++; $display("FAIL edge_silence got %0d expected 0", silence); end
        checks++; if (note_code !== 4'd13) begin errors++; $display("FAIL edge_code_hold got %0d expected 13", note_code); end
        fall(SIL + 1);
        t = last_fall_cyc;
        fall(68);
        checks++; if (note_code !== 4'd0) begin errors++; $display("FAIL edge_code got %0d expected 0", note_code); end
        checks++; if (last_pulse_code !== 4'd0) begin errors++; $display("FAIL edge_pulse_code got %0d expected 0", last_pulse_code); end
        checks++; if (last_pulse_cyc - t != SIL + 3) begin errors++; $display("FAIL edge_timing got %0d expected %0d", last_pulse_cyc - t, SIL + 3); end
        checks++; if (silence !== 1'b0) begin errors++; $display("FAIL edge_reacq got %0d expected 0", silence); end
    endtask

    task automatic test_acq_no_lock();
        int p0;
        go_idle();
        p0 = pulses;
        for (int i = 0; i < 6; i++) begin
            fall(72);
            fall(84);
        end
        checks++; if (note_code !== 4'd0) begin errors++; $display("FAIL acq_code got %0d expected 0", note_code); end
        checks++; if (silence !== 1'b0) begin errors++; $display("FAIL acq_silence got %0d expected 0", silence); end
        checks++; if (pulses != p0) begin errors++; $display("FAIL acq_pulses got %0d expected %0d", pulses, p0); end
        repeat (3) fall(300);
        checks++; if (note_period !== 18'd300) begin errors++; $display("FAIL nomatch_period got %0d expected 300", note_period); end
        repeat (3) fall(70);
        checks++; if (note_period !== 18'd70) begin errors++; $display("FAIL tol_period got %0d expected 70", note_period); end
        checks++; if (note_code !== 4'd0) begin errors++; $display("FAIL tol_code got %0d expected 0", note_code); end
        repeat (2) fall(69);
        checks++; if (note_period !== 18'd69) begin errors++; $display("FAIL track_period got %0d expected 69", note_period); end
        checks++; if (note_code !== 4'd0) begin errors++; $display("FAIL track_code_held got %0d expected 0", note_code); end
        checks++; if (pulses != p0) begin errors++; $display("FAIL nomatch_pulses got %0d expected %0d", pulses, p0); end
    endtask

    task automatic test_random();
        int p;
        int n;
        int r;
        for (int it = 0; it < 50; it++) begin
            r = int'($urandom_range(0, 9));
            if (r == 9) begin
                go_idle();
                n = 0;
                p = 0;
            end else if (r < 6) begin
                p = nominal(int'($urandom_range(1, 14))) + int'($urandom_range(0, 2)) - 1;
                n = int'($urandom_range(1, 4));
            end else begin
                p = int'($urandom_range(58, 400));
                n = int'($urandom_range(1, 3));
            end
            for (int j = 0; j <= n; j++) begin
                if (j < n) fall(p);
                checks++; if (note_code !== 4'(m_code)) begin errors++; $display("FAIL rnd_code got %0d expected %0d", note_code, m_code); end
                checks++; if (note_period !== 18'(m_per)) begin errors++; $display("FAIL rnd_period got %0d expected %0d", note_period, m_per); end
                checks++; if (silence !== (m_state == 0)) begin errors++; $display("FAIL rnd_silence got %0d expected %0d", silence, m_state == 0); end
                checks++; if (event_cnt !== 8'(m_events)) begin errors++; $display("FAIL rnd_events got %0d expected %0d", event_cnt, 8'(m_events)); end
                checks++; if (pulses - pulse_base != m_events) begin errors++; $display("FAIL rnd_pulses got %0d expected %0d", pulses - pulse_base, m_events); end
            end
        end
    endtask

    task automatic test_wrap();
        int i;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (700) @(negedge clk);
        repeat (3) fall(68);
        i = 0;
        while (m_events < 255 && i < 1200) begin
            fall(((i / 2) % 2 == 0) ? 60 : 68);
            i++;
        end
        checks++; if (event_cnt !== 8'd255) begin errors++; $display("FAIL wrap_255 got %0d expected 255", event_cnt); end
        while (m_events < 256 && i < 1200) begin
            fall(((i / 2) % 2 == 0) ? 60 : 68);
            i++;
        end
        checks++; if (event_cnt !== 8'd0) begin errors++; $display("FAIL wrap_0 got %0d expected 0", event_cnt); end
        checks++; if (pulses - pulse_base != 256) begin errors++; $display("FAIL wrap_pulses got %0d expected 256", pulses - pulse_base); end
    endtask

    task automatic test_reset_mid_track();
        int p0;
        checks++; if (note_code === 4'd0) begin errors++; $display("FAIL mid_pre_code got %0d expected nonzero", note_code); end
        p0 = pulses;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (note_code !== 4'd0) begin errors++; $display("FAIL mid_code got %0d expected 0", note_code); end
        checks++; if (note_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %0d expected 0", note_valid); end
        checks++; if (note_period !== 18'd0) begin errors++; $display("FAIL mid_period got %0d expected 0", note_period); end
        checks++; if (silence !== 1'b1) begin errors++; $display("FAIL mid_silence got %0d expected 1", silence); end
        checks++; if (event_cnt !== 8'd0) begin errors++; $display("FAIL mid_events got %0d expected 0", event_cnt); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        checks++; if (pulses != p0) begin errors++; $display("FAIL mid_pulses got %0d expected %0d", pulses, p0); end
        model_reset();
        repeat (700) @(negedge clk);
        repeat (2) fall(68);
        checks++; if (note_code !== 4'd0) begin errors++; $display("FAIL mid_reacq_early got %0d expected 0", note_code); end
        fall(68);
        checks++; if (note_code !== 4'd13) begin errors++; $display("FAIL mid_reacq got %0d expected 13", note_code); end
    endtask

    initial begin
        test_reset();
        test_la();
        test_do_low();
        test_la_si();
        test_silence();
        test_timeout_edge();
        test_acq_no_lock();
        test_random();
        test_wrap();
        test_reset_mid_track();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        checks++;
        errors++;
        $display("FAIL watchdog got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
